// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: feeds an external 1-bit ALU slice one bit per
// cycle, LSB first, and assembles the WIDTH-bit result and its flags.
module alu_serial_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [1:0]       alu_op,
    input  logic             alu_s,
    input  logic             alu_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_SUB = 2'b11;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_q;
    logic [1:0]       op_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic             is_arith;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    // Arithmetic ops have op[1] set; the slice result enters the result MSB
    // so that after WIDTH shifts bit 0 ends up at the LSB.
    assign is_arith = op_q[1];
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign res_next = {alu_s, res_q[WIDTH-1:1]};

    // Sequencer: accept in IDLE, shift one bit per cycle in RUN, hold in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_q   <= '0;
            op_q    <= 2'b00;
            carry_q <= 1'b0;
            cnt     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= in_a;
                        b_sh    <= in_b;
                        op_q    <= in_op;
                        carry_q <= (in_op == OP_SUB);
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_q   <= res_next;
                    carry_q <= alu_cout;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        // carry_q here is the carry into the MSB, alu_cout the carry out of it
                        cout_q <= is_arith & alu_cout;
                        ovf_q  <= is_arith & (carry_q ^ alu_cout);
                        zero_q <= (res_next == '0);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and result outputs come straight from registered state.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_res   = res_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

    // Slice drive is only active while running; op is always presented.
    assign alu_a   = (state == RUN) & a_sh[0];
    assign alu_b   = (state == RUN) & b_sh[0];
    assign alu_cin = (state == RUN) & carry_q;
    assign alu_op  = op_q;

endmodule
